sram_ctrl: RTL and testbench
============================

Name: sram_ctrl

Overview:
Synchronous initiator for the external 256Kx16 asynchronous SRAM on the iCE40HX8K-EVB. It converts a single-clock valid/ready request interface into the SRAM's cs_n/wr_n/rd_n strobe sequence. It holds address, write data and the data-bus output enable stable around each strobe, captures read data, and returns a one-cycle response pulse. It sits between the CPU/bus fabric and the SRAM pins; the top level builds the tristate data pad from sram_dout, sram_oe and sram_din.

Parameters:
ACCESS_CYCLES, 2, clock cycles the rd_n/wr_n strobe is held low (legal range 1..15; ACCESS_CYCLES x clock period must be >= 10 ns)
ADDR_W, 18, SRAM address width
DATA_W, 16, SRAM data width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request this cycle
req_we  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse: transaction complete (reads and writes)
rsp_rdata  output  DATA_W  read data, valid with rsp_valid on reads
sram_cs_n  output  1  chip select, active low
sram_wr_n  output  1  write strobe, active low
sram_rd_n  output  1  read strobe (output enable), active low
sram_addr  output  ADDR_W  SRAM address
sram_dout  output  DATA_W  data driven to SRAM on writes
sram_oe  output  1  1 = FPGA drives the data pad
sram_din  input  DATA_W  data from SRAM pad

Behaviour:
- All sram_* outputs, rsp_valid and rsp_rdata are driven directly from flops; no combinational path from the request inputs to the SRAM pins.
- Reset (async assert; removal synchronous to clk):
  - state=IDLE; sram_cs_n=sram_wr_n=sram_rd_n=1; sram_oe=0; sram_addr=0; sram_dout=0.
  - rsp_valid=0; rsp_rdata=0; counter=0; req_ready=0 while rst_n low.
- FSM states: IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
- req_ready = 1 only in IDLE with rst_n high. A request is accepted on the rising edge where req_valid && req_ready. At that edge req_we, req_addr and req_wdata are latched into sram_addr and sram_dout. Request inputs are ignored at all other times.
- SETUP (1 cycle):
  - sram_cs_n=0; sram_addr valid; strobes still high.
  - sram_oe = latched we (data driven before wr_n falls).
- ACCESS (exactly ACCESS_CYCLES cycles, 4-bit down-counter):
  - Write: sram_wr_n=0.
  - Read: sram_rd_n=0, sram_oe=0.
  - On a read, sram_din is sampled into rsp_rdata at the clock edge that ends ACCESS.
- HOLD (1 cycle):
  - Strobes high; sram_cs_n=0; sram_addr, sram_dout and sram_oe unchanged (hold time).
  - rsp_valid=1 for exactly this cycle.
- Return to IDLE: sram_cs_n=1, sram_oe=0, req_ready=1.
- Latency and throughput:
  - Accept edge to rsp_valid high: ACCESS_CYCLES+2 cycles.
  - Minimum spacing between accept edges: ACCESS_CYCLES+3. The IDLE cycle is mandatory, giving one cycle of cs_n high between accesses.
- rsp_rdata keeps the last read value; it does not change on writes.
- sram_wr_n and sram_rd_n are never low simultaneously. Neither strobe is low while sram_cs_n is high. sram_oe is never 1 while sram_rd_n=0.
- Reset mid-transaction: all strobes go high and sram_oe=0 immediately with no clock edge. No rsp_valid is generated for the aborted access. An aborted write leaves that SRAM word undefined. After release the FSM is in IDLE.

Test Plan:
1. Reset, ACCESS_CYCLES=2: hold rst_n low 5 cycles with req_valid=1 -> strobes and cs_n =1, sram_oe=0, req_ready=0, rsp_valid=0, rsp_rdata=0x0000. Release -> req_ready=1 next cycle.
2. Write 0x3FFFF/0xA5C3 with the SRAM model attached:
   - sram_cs_n low exactly 4 cycles; sram_wr_n low exactly 2 cycles, starting one cycle after cs_n falls.
   - sram_oe high for all 4 cycles; rsp_valid a single pulse in cycle 4.
3. Read 0x3FFFF after test 2 -> sram_rd_n low 2 cycles, sram_oe=0 throughout, rsp_valid pulse with rsp_rdata=0xA5C3.
4. Back-to-back with req_valid held high: write 0x00000/0x1234, then read 0x00000 -> accepts exactly 5 edges apart, cs_n high for 1 cycle between accesses, read returns 0x1234.
5. Assert rst_n low during ACCESS of a write to 0x00010 -> strobes high and sram_oe=0 without a clock edge, no rsp_valid. After release, a write/read of 0x00010/0xBEEF returns 0xBEEF.
6. Parameter sweep ACCESS_CYCLES=1 and 4 -> strobe low width equals 1 and 4 cycles, response latency 3 and 6 cycles, reads match written data 0x5A5A.

Source files
------------

// File: rtl/sram_ctrl.sv
// sram_ctrl: valid/ready request port to async SRAM cs_n/wr_n/rd_n strobe sequencer
module sram_ctrl #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 18,
    parameter int DATA_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              sram_cs_n,
    output logic              sram_wr_n,
    output logic              sram_rd_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_dout,
    output logic              sram_oe,
    input  logic [DATA_W-1:0] sram_din
);
    localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic              cs_n_q, cs_n_d;
    logic              wr_n_q, wr_n_d;
    logic              rd_n_q, rd_n_d;
    logic              oe_q, oe_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              accept;

    assign req_ready = (state_q == IDLE) && rst_n;
    assign accept    = req_valid && req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign sram_cs_n = cs_n_q;
    assign sram_wr_n = wr_n_q;
    assign sram_rd_n = rd_n_q;
    assign sram_oe   = oe_q;
    assign sram_addr = addr_q;
    assign sram_dout = dout_q;

    // State and output registers; reset parks every strobe high and releases the pad at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            addr_q      <= '0;
            dout_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            rd_n_q      <= rd_n_d;
            oe_q        <= oe_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
        end
    end

    // Next state: one setup cycle, counted access window, one hold cycle, mandatory idle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = accept ? SETUP : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (cnt_q == 4'd0) ? HOLD : ACCESS;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next pin values, registered so the SRAM sees no combinational path from the request port
    always_comb begin
        cnt_d       = cnt_q;
        we_d        = we_q;
        cs_n_d      = cs_n_q;
        wr_n_d      = wr_n_q;
        rd_n_d      = rd_n_q;
        oe_d        = oe_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d   = req_we;
                    addr_d = req_addr;
                    dout_d = req_wdata;
                    cs_n_d = 1'b0;
                    oe_d   = req_we;
                end
            end
            SETUP: begin
                cnt_d  = CNT_LOAD;
                wr_n_d = !we_q;
                rd_n_d = we_q;
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    wr_n_d      = 1'b1;
                    rd_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rdata_d     = we_q ? rdata_q : sram_din;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                cs_n_d = 1'b1;
                oe_d   = 1'b0;
            end
            default: begin
                cs_n_d = 1'b1;
                oe_d   = 1'b0;
            end
        endcase
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: three controllers (ACCESS_CYCLES 2/1/4) against SRAM pin models and a cycle-offset reference model
module tb_sram_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  rv = '0;
    logic        req_we = 1'b0;
    logic [17:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [2:0]  rdy_v, rsp_v, cs_v, wr_v, rd_v, oe_v;
    logic [17:0] addr_v [3];
    logic [15:0] dout_v [3];
    logic [15:0] rdata_v [3];
    int          errors = 0;
    int          checks = 0;
    int          acs [3] = '{2, 1, 4};

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : u
        localparam int AC = (g == 0) ? 2 : (g == 1) ? 1 : 4;
        logic [15:0] pins [logic [17:0]];
        logic [15:0] mmem [logic [17:0]];
        logic [15:0] din;
        bit          act = 1'b0;
        bit          mwe = 1'b0;
        bit          w;
        int          k = 0;
        logic [17:0] maddr = '0;
        logic [15:0] mdata = '0;
        logic [15:0] exp_rdata = '0;

        sram_ctrl #(.ACCESS_CYCLES(AC), .ADDR_W(18), .DATA_W(16)) dut (
            .clk(clk), .rst_n(rst_n), .req_valid(rv[g]), .req_ready(rdy_v[g]),
            .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
            .rsp_valid(rsp_v[g]), .rsp_rdata(rdata_v[g]),
            .sram_cs_n(cs_v[g]), .sram_wr_n(wr_v[g]), .sram_rd_n(rd_v[g]),
            .sram_addr(addr_v[g]), .sram_dout(dout_v[g]), .sram_oe(oe_v[g]), .sram_din(din)
        );

        // SRAM pins: stores while selected and write-strobed, drives data only while read-strobed
        always @(posedge clk) if (!cs_v[g] && !wr_v[g]) pins[addr_v[g]] = dout_v[g];
        always @* din = (!cs_v[g] && !rd_v[g]) ? (pins.exists(addr_v[g]) ? pins[addr_v[g]] : 16'hDEAD) : 16'h0000;

        // Reference: k counts cycles since the accept edge; transaction occupies cycles 1..AC+2
        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                if (act && mwe) mmem.delete(maddr);
                act = 1'b0;
                k = 0;
                exp_rdata = '0;
            end else if (act) begin
                k++;
                if (k == AC + 2) begin
                    if (mwe) mmem[maddr] = mdata;
                    else exp_rdata = mmem.exists(maddr) ? mmem[maddr] : 16'hDEAD;
                end
                if (k == AC + 3) act = 1'b0;
            end else if (rv[g]) begin
                act = 1'b1;
                k = 1;
                mwe = req_we;
                maddr = req_addr;
                mdata = req_wdata;
            end
        end

        always @(negedge clk) begin
            w = act && k >= 2 && k <= AC + 1;
            chk($sformatf("u%0d.req_ready", g), rdy_v[g], !act && rst_n);
            chk($sformatf("u%0d.cs_n", g), cs_v[g], !act);
            chk($sformatf("u%0d.wr_n", g), wr_v[g], !(w && mwe));
            chk($sformatf("u%0d.rd_n", g), rd_v[g], !(w && !mwe));
            chk($sformatf("u%0d.oe", g), oe_v[g], act && mwe);
            chk($sformatf("u%0d.rsp_valid", g), rsp_v[g], act && k == AC + 2);
            chk($sformatf("u%0d.rsp_rdata", g), rdata_v[g], exp_rdata);
            if (act) chk($sformatf("u%0d.addr", g), addr_v[g], maddr);
            if (act && mwe) chk($sformatf("u%0d.dout", g), dout_v[g], mdata);
        end
    end

    task automatic wait_ready(input int g);
        int n = 0;
        while (!rdy_v[g] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("ready_timeout", 32'(n < 50), 1);
    endtask

    task automatic txn(input int g, input bit we, input logic [17:0] a, input logic [15:0] d,
                       output int lat, output int sw, output int csw, output int ow, output logic [15:0] rd);
        lat = 0; sw = 0; csw = 0; ow = 0; rd = '0;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = d; rv[g] = 1'b1;
        wait_ready(g);
        @(posedge clk);
        #1 rv[g] = 1'b0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            csw += int'(!cs_v[g]);
            sw  += int'(!wr_v[g] || !rd_v[g]);
            ow  += int'(oe_v[g]);
            if (rsp_v[g]) begin
                rd = rdata_v[g];
                break;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, lat, sw, csw, ow;
        logic [15:0] rd;
        #1 rst_n = 1'b0;
        rv = '1; req_we = 1'b1; req_addr = 18'h3FFFF; req_wdata = 16'hFFFF;
        repeat (5) @(negedge clk);
        chk("rst_cs_n", cs_v, 3'b111);
        chk("rst_wr_n", wr_v, 3'b111);
        chk("rst_rd_n", rd_v, 3'b111);
        chk("rst_oe", oe_v, 3'b000);
        chk("rst_ready", rdy_v, 3'b000);
        chk("rst_rsp", rsp_v, 3'b000);
        chk("rst_rdata", rdata_v[0], 16'h0000);
        #2 rv = '0; rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", rdy_v, 3'b111);

        txn(0, 1'b1, 18'h3FFFF, 16'hA5C3, lat, sw, csw, ow, rd);
        chk("wr_latency", lat, 4);
        chk("wr_strobe_width", sw, 2);
        chk("wr_cs_width", csw, 4);
        chk("wr_oe_width", ow, 4);

        txn(0, 1'b0, 18'h3FFFF, 16'h0000, lat, sw, csw, ow, rd);
        chk("rd_data", rd, 16'hA5C3);
        chk("rd_strobe_width", sw, 2);
        chk("rd_oe_width", ow, 0);
        chk("rd_latency", lat, 4);

        @(negedge clk);
        req_we = 1'b1; req_addr = 18'h00000; req_wdata = 16'h1234; rv[0] = 1'b1;
        wait_ready(0);
        @(posedge clk);
        #1 req_we = 1'b0; req_wdata = 16'hFFFF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rdy_v[0] && n < 20);
        chk("b2b_spacing", n, 5);
        @(posedge clk);
        #1 rv[0] = 1'b0;
        lat = 0; rd = '0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (rsp_v[0]) begin
                rd = rdata_v[0];
                break;
            end
        end
        chk("b2b_rdata", rd, 16'h1234);
        chk("b2b_latency", lat, 4);
        @(negedge clk);

        @(negedge clk);
        req_we = 1'b1; req_addr = 18'h00010; req_wdata = 16'h7777; rv[0] = 1'b1;
        wait_ready(0);
        @(posedge clk);
        #1 rv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_wr_low", wr_v[0], 0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_cs_n", cs_v[0], 1);
        chk("abort_wr_n", wr_v[0], 1);
        chk("abort_rd_n", rd_v[0], 1);
        chk("abort_oe", oe_v[0], 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        txn(0, 1'b1, 18'h00010, 16'hBEEF, lat, sw, csw, ow, rd);
        txn(0, 1'b0, 18'h00010, 16'h0000, lat, sw, csw, ow, rd);
        chk("abort_reread", rd, 16'hBEEF);

        for (int g = 1; g < 3; g++) begin
            txn(g, 1'b1, 18'h00ABC, 16'h5A5A, lat, sw, csw, ow, rd);
            chk($sformatf("sweep%0d_wr_latency", g), lat, acs[g] + 2);
            chk($sformatf("sweep%0d_wr_width", g), sw, acs[g]);
            txn(g, 1'b0, 18'h00ABC, 16'h0000, lat, sw, csw, ow, rd);
            chk($sformatf("sweep%0d_rd_data", g), rd, 16'h5A5A);
            chk($sformatf("sweep%0d_rd_latency", g), lat, acs[g] + 2);
            chk($sformatf("sweep%0d_rd_width", g), sw, acs[g]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
